if_fetch: RTL and testbench

- Instruction-fetch stage of the 16-bit pipeline.
- Writes the IF/ID pipeline register: drives its instruction word, sequential PC, write enable and flush.
- Owns the architectural fetch PC and runs a variable-latency request/ack handshake to instruction memory.
- Absorbs pipeline stalls in a one-entry hold buffer and squashes wrong-path fetches on branch redirect.

---
 rtl/if_fetch_if.sv | 24 ++
 rtl/if_fetch.sv | 180 ++++++++++++++++++
 tb/tb_if_fetch.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/ack bus between the fetch stage
// (master) and instruction memory (slave). The request is held, with its
// address, until the memory acknowledges it. The acknowledge may come in
// the same cycle as the request.
interface if_fetch_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the 16-bit pipeline.
// - Owns the fetch PC and drives the IF/ID register inputs.
// - Runs a variable-latency request/ack handshake to instruction memory.
// - Parks a stalled instruction in a one-entry hold buffer.
// - Drains, and discards, an in-flight request when a branch redirect arrives.
// Optional feature: define FETCH_HALT_EN so that consuming an HLT
// instruction (opcode 4'hF) parks the stage in HALTED until a redirect
// arrives.
module if_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  if_fetch_if.master  imem,
  output logic [15:0] inst_data_o,
  output logic [15:0] pc_next_o,
  output logic        if_valid_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_DRAIN  = 2'd2
`ifdef FETCH_HALT_EN
    ,
    ST_HALTED = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] hold_inst_q, hold_inst_d;
  logic [15:0] drain_addr_q, drain_addr_d;

  logic        req_s;
  logic [15:0] addr_s;
  logic        valid_s;
  logic [15:0] inst_src_s;
  logic [15:0] pc_inc_s;
  logic [15:0] target_s;

`ifdef FETCH_HALT_EN
  // HLT is recognised purely by its opcode nibble
  function automatic logic is_hlt(input logic [15:0] inst);
    return (inst[15:12] == 4'hF);
  endfunction
`endif

  // mod-2^16 increment; fetch addresses are always halfword aligned
  assign pc_inc_s = fetch_pc_q + 16'd2;
  assign target_s = redirect_pc_i & 16'hFFFE;

  // State, fetch PC, hold buffer and drain address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      fetch_pc_q   <= 16'h0000;
      hold_inst_q  <= 16'h0000;
      drain_addr_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_inst_q  <= hold_inst_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  // Next-state and datapath decode; redirect overrides everything else
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    hold_inst_d  = hold_inst_q;
    drain_addr_d = drain_addr_q;
    req_s        = 1'b0;
    addr_s       = fetch_pc_q;
    valid_s      = 1'b0;
    inst_src_s   = 16'h0000;

    case (state_q)
      ST_FETCH: begin
        req_s = 1'b1;
        if (redirect_i) begin
          fetch_pc_d = target_s;
          if (imem.imem_ack) begin
            state_d = ST_FETCH;
          end else begin
            // keep the old address on the bus until memory answers it
            drain_addr_d = fetch_pc_q;
            state_d      = ST_DRAIN;
          end
        end else if (imem.imem_ack) begin
          valid_s    = 1'b1;
          inst_src_s = imem.imem_rdata;
          if (stall_i) begin
            hold_inst_d = imem.imem_rdata;
            state_d     = ST_HOLD;
          end else begin
            fetch_pc_d = pc_inc_s;
`ifdef FETCH_HALT_EN
            if (is_hlt(imem.imem_rdata)) begin
              fetch_pc_d = fetch_pc_q;
              state_d    = ST_HALTED;
            end else begin
              state_d = ST_FETCH;
            end
`endif
          end
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_HOLD: begin
        // fetch_pc still points at the held instruction, so pc_next is right
        inst_src_s = hold_inst_q;
        if (redirect_i) begin
          fetch_pc_d = target_s;
          state_d    = ST_FETCH;
        end else if (!stall_i) begin
          valid_s    = 1'b1;
          fetch_pc_d = pc_inc_s;
          state_d    = ST_FETCH;
`ifdef FETCH_HALT_EN
          if (is_hlt(hold_inst_q)) begin
            fetch_pc_d = fetch_pc_q;
            state_d    = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
          end
`endif
        end else begin
          valid_s = 1'b1;
        end
      end

      ST_DRAIN: begin
        req_s  = 1'b1;
        addr_s = drain_addr_q;
        if (redirect_i) begin
          fetch_pc_d = target_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (imem.imem_ack) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DRAIN;
        end
      end

`ifdef FETCH_HALT_EN
      ST_HALTED: begin
        if (redirect_i) begin
          fetch_pc_d = target_s;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_HALTED;
        end
      end
`endif

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // The request and valid are forced low while reset is asserted
  assign imem.imem_req  = req_s & rst_n;
  assign imem.imem_addr = addr_s;
  assign if_valid_o     = valid_s & rst_n;
  assign inst_data_o    = if_valid_o ? inst_src_s : 16'h0000;
  assign pc_next_o      = pc_inc_s;
  assign ifid_write_o   = ~stall_i;
  assign ifid_flush_o   = redirect_i | ~if_valid_o;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed test of if_fetch against a behavioural instruction
// memory. The memory returns each address as its data word, except that it
// can return 16'hF000 at address 0. Its ack comes after a configurable
// number of wait cycles.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst_data;
  logic [15:0] pc_next;
  logic        if_valid;
  logic        ifid_write;
  logic        ifid_flush;

  logic [3:0]  waits;
  logic [3:0]  wait_cnt;
  logic        hlt_zero;

  int errors = 0;
  int checks = 0;

  if_fetch_if bus();

  if_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem         (bus),
    .inst_data_o  (inst_data),
    .pc_next_o    (pc_next),
    .if_valid_o   (if_valid),
    .ifid_write_o (ifid_write),
    .ifid_flush_o (ifid_flush)
  );

  always #5 clk = ~clk;

  // memory model: ack after `waits` cycles of a held request
  assign bus.imem_ack   = bus.imem_req && (wait_cnt == waits);
  assign bus.imem_rdata = (hlt_zero && bus.imem_addr == 16'h0000) ? 16'hF000 : bus.imem_addr;

  // memory wait-state counter, reset with the fetch stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 4'd0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 4'd1;
    else wait_cnt <= 4'd0;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    waits = 4'd0; hlt_zero = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (inst_data !== 16'h0000) begin errors++; $display("FAIL reset_inst: got %h want 0000", inst_data); end
    checks++; if (pc_next !== 16'h0002) begin errors++; $display("FAIL reset_pc_next: got %h want 0002", pc_next); end
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %b want 1", ifid_flush); end
    checks++; if (ifid_write !== 1'b1) begin errors++; $display("FAIL reset_write: got %b want 1", ifid_write); end
    stall = 1'b1; #1;
    checks++; if (ifid_write !== 1'b0) begin errors++; $display("FAIL reset_write_stall: got %b want 0", ifid_write); end
    stall = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'(2 * i)) begin errors++; $display("FAIL zw_req[%0d]: got %b/%h want 1/%h", i, bus.imem_req, bus.imem_addr, 16'(2 * i)); end
      checks++; if (if_valid !== 1'b1 || inst_data !== 16'(2 * i)) begin errors++; $display("FAIL zw_inst[%0d]: got %b/%h want 1/%h", i, if_valid, inst_data, 16'(2 * i)); end
      checks++; if (pc_next !== 16'(2 * i + 2)) begin errors++; $display("FAIL zw_pc_next[%0d]: got %h want %h", i, pc_next, 16'(2 * i + 2)); end
      checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL zw_flush[%0d]: got %b want 0", i, ifid_flush); end
      next_cycle();
    end
  endtask

  task automatic test_two_wait();
    logic [15:0] a;
    waits = 4'd2;
    for (int k = 0; k < 2; k++) begin
      a = 16'h0006 + 16'(2 * k);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== a) begin errors++; $display("FAIL w2_req[%0d.%0d]: got %b/%h want 1/%h", k, c, bus.imem_req, bus.imem_addr, a); end
        checks++; if (if_valid !== (c == 2) || ifid_flush !== (c != 2)) begin errors++; $display("FAIL w2_valid[%0d.%0d]: got v=%b f=%b want v=%b", k, c, if_valid, ifid_flush, (c == 2)); end
        if (c == 2) begin
          checks++; if (inst_data !== a || pc_next !== a + 16'd2) begin errors++; $display("FAIL w2_data[%0d]: got %h/%h want %h/%h", k, inst_data, pc_next, a, a + 16'd2); end
        end
        next_cycle();
      end
    end
    waits = 4'd0;
  endtask

  task automatic test_stall();
    redirect = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || ifid_flush !== 1'b1) begin errors++; $display("FAIL st_redir: got v=%b f=%b want v=0 f=1", if_valid, ifid_flush); end
    next_cycle();
    redirect = 1'b0; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || inst_data !== 16'h0010 || pc_next !== 16'h0012) begin errors++; $display("FAIL st_hold[%0d]: got %b/%h/%h want 1/0010/0012", c, if_valid, inst_data, pc_next); end
      checks++; if (bus.imem_req !== (c == 0) || ifid_write !== 1'b0) begin errors++; $display("FAIL st_req[%0d]: got req=%b wr=%b want req=%b wr=0", c, bus.imem_req, ifid_write, (c == 0)); end
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || inst_data !== 16'h0010 || pc_next !== 16'h0012 || ifid_flush !== 1'b0) begin errors++; $display("FAIL st_exit: got %b/%h/%h f=%b want 1/0010/0012 f=0", if_valid, inst_data, pc_next, ifid_flush); end
    checks++; if (bus.imem_req !== 1'b0 || ifid_write !== 1'b1) begin errors++; $display("FAIL st_exit_req: got req=%b wr=%b want req=0 wr=1", bus.imem_req, ifid_write); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0012 || inst_data !== 16'h0012) begin errors++; $display("FAIL st_next: got %b/%h/%h want 1/0012/0012", bus.imem_req, bus.imem_addr, inst_data); end
    next_cycle();
  endtask

  task automatic test_redirect_drain();
    redirect = 1'b1; redirect_pc = 16'h0020;
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0101; waits = 4'd3;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0020 || if_valid !== 1'b0 || ifid_flush !== 1'b1) begin errors++; $display("FAIL dr_start: got %b/%h v=%b f=%b want 1/0020 v=0 f=1", bus.imem_req, bus.imem_addr, if_valid, ifid_flush); end
    next_cycle();
    redirect = 1'b0;
    for (int c = 1; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0020 || if_valid !== 1'b0 || ifid_flush !== 1'b1) begin errors++; $display("FAIL dr_wait[%0d]: got %b/%h v=%b f=%b want 1/0020 v=0 f=1", c, bus.imem_req, bus.imem_addr, if_valid, ifid_flush); end
      next_cycle();
    end
    waits = 4'd0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin errors++; $display("FAIL dr_target: got %b/%h want 1/0100", bus.imem_req, bus.imem_addr); end
    checks++; if (if_valid !== 1'b1 || inst_data !== 16'h0100 || pc_next !== 16'h0102) begin errors++; $display("FAIL dr_data: got %b/%h/%h want 1/0100/0102", if_valid, inst_data, pc_next); end
    next_cycle();
  endtask

  task automatic test_redirect_stall_hold();
    stall = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || inst_data !== 16'h0102) begin errors++; $display("FAIL rs_fetch: got %b/%h want 1/0102", if_valid, inst_data); end
    next_cycle();
    redirect = 1'b1; redirect_pc = 16'h0200;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || ifid_flush !== 1'b1 || ifid_write !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL rs_both: got v=%b f=%b w=%b req=%b want 0/1/0/0", if_valid, ifid_flush, ifid_write, bus.imem_req); end
    next_cycle();
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0200 || if_valid !== 1'b1 || inst_data !== 16'h0200) begin errors++; $display("FAIL rs_target: got %b/%h v=%b %h want 1/0200 v=1 0200", bus.imem_req, bus.imem_addr, if_valid, inst_data); end
    next_cycle();
  endtask

  task automatic test_wrap();
    hlt_zero = 1'b1;
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL wr_redir: got %b want 0", if_valid); end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_addr !== 16'hFFFE || inst_data !== 16'hFFFE || pc_next !== 16'h0000 || if_valid !== 1'b1) begin errors++; $display("FAIL wr_top: got %h/%h/%h v=%b want FFFE/FFFE/0000 v=1", bus.imem_addr, inst_data, pc_next, if_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000 || if_valid !== 1'b1 || inst_data !== 16'hF000 || pc_next !== 16'h0002) begin errors++; $display("FAIL wr_zero: got %b/%h v=%b %h/%h want 1/0000 v=1 F000/0002", bus.imem_req, bus.imem_addr, if_valid, inst_data, pc_next); end
    next_cycle();
`ifdef FETCH_HALT_EN
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b0 || if_valid !== 1'b0 || ifid_flush !== 1'b1) begin errors++; $display("FAIL hlt_idle[%0d]: got req=%b v=%b f=%b want 0/0/1", c, bus.imem_req, if_valid, ifid_flush); end
      next_cycle();
    end
    redirect = 1'b1; redirect_pc = 16'h0041;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL hlt_redir: got req=%b want 0", bus.imem_req); end
    next_cycle();
    redirect = 1'b0; hlt_zero = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040 || inst_data !== 16'h0040) begin errors++; $display("FAIL hlt_resume: got %b/%h/%h want 1/0040/0040", bus.imem_req, bus.imem_addr, inst_data); end
    next_cycle();
`else
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0002 || if_valid !== 1'b1 || inst_data !== 16'h0002 || pc_next !== 16'h0004) begin errors++; $display("FAIL wr_after: got %b/%h v=%b %h/%h want 1/0002 v=1 0002/0004", bus.imem_req, bus.imem_addr, if_valid, inst_data, pc_next); end
    next_cycle();
    hlt_zero = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_two_wait();
    test_stall();
    test_redirect_drain();
    test_redirect_stall_hold();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
